// File: rtl/byte_align_pkg.sv
// Shared types and constants for the byte aligner.
package byte_align_pkg;

  // Alignment FSM encoding
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  // Default frame sync byte; every one of its 8 rotations is distinct
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hF4;

endpackage

// File: rtl/rotr8.sv
// Combinational 8-bit rotate-right: out[i] = in[(i+sh) mod 8].
// Built as three log stages (1, 2, 4) of 2:1 muxes.
module rotr8 (
  input  logic [7:0] in,
  input  logic [2:0] sh,
  output logic [7:0] out
);

  logic [7:0] stg1;
  logic [7:0] stg2;

  assign stg1 = sh[0] ? {in[0],     in[7:1]}   : in;
  assign stg2 = sh[1] ? {stg1[1:0], stg1[7:2]} : stg1;
  assign out  = sh[2] ? {stg2[3:0], stg2[7:4]} : stg2;

endmodule

// File: rtl/byte_aligner.sv
// Byte aligner: hunts for the rotation that turns the raw deserializer byte
// stream into aligned bytes, verifies the sync byte at a fixed frame period
// and holds lock until too many sync bytes in a row are missed.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_HUNT   | no alignment; stepping shift_mag every FRAME_LEN misses
// ST_VERIFY | candidate alignment; counting matching syncs toward lock
// ST_LOCKED | aligned; counting consecutive missed syncs toward loss
module byte_aligner
  import byte_align_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int         FRAME_LEN = 16,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       locked,
  output logic [2:0] shift_mag
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [FW-1:0] F_LAST    = FW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

  align_state_e  state_q, state_d;
  logic [2:0]    shift_q, shift_d;
  logic [FW-1:0] hcnt_q,  hcnt_d;
  logic [FW-1:0] fcnt_q,  fcnt_d;
  logic [GW-1:0] good_q,  good_d;
  logic [MW-1:0] miss_q,  miss_d;
  logic          sof_d;

  logic [7:0]    rot;
  logic          match;
  logic          sync_pos;
  logic [FW-1:0] fcnt_inc;

  rotr8 u_rotr8 (
    .in  (in_data),
    .sh  (shift_q),
    .out (rot)
  );

  assign match    = (rot == SYNC_WORD);
  assign sync_pos = (fcnt_q == '0);
  assign fcnt_inc = (fcnt_q == F_LAST) ? '0 : fcnt_q + 1'b1;

  // Next-state logic; idle cycles leave every counter untouched
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hcnt_d  = hcnt_q;
    fcnt_d  = fcnt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    sof_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (match) begin
            state_d = ST_VERIFY;
            good_d  = GW'(1);
            fcnt_d  = FW'(1);
            hcnt_d  = '0;
            miss_d  = '0;
          end else if (hcnt_q == F_LAST) begin
            shift_d = shift_q + 3'd1;
            hcnt_d  = '0;
          end else begin
            hcnt_d  = hcnt_q + 1'b1;
          end
        end
        ST_VERIFY: begin
          fcnt_d = fcnt_inc;
          if (sync_pos) begin
            if (match) begin
              good_d = good_q + 1'b1;
              if (good_q == GOOD_LAST) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              // Candidate rotation failed; resume hunting at the next one
              state_d = ST_HUNT;
              shift_d = shift_q + 3'd1;
              hcnt_d  = '0;
              good_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          fcnt_d = fcnt_inc;
          if (sync_pos) begin
            if (match) begin
              miss_d = '0;
              sof_d  = 1'b1;
            end else if (miss_q == MISS_LAST) begin
              // Lock lost: re-hunt starting from the rotation that last worked
              state_d = ST_HUNT;
              hcnt_d  = '0;
              miss_d  = '0;
              good_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State, counters and registered outputs; reset wins over in_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      shift_q   <= 3'd0;
      hcnt_q    <= '0;
      fcnt_q    <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_sof   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hcnt_q    <= hcnt_d;
      fcnt_q    <= fcnt_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      out_valid <= in_valid;
      out_sof   <= sof_d;
      locked    <= (state_d == ST_LOCKED);
      if (in_valid) out_data <= rot;
    end
  end

  assign shift_mag = shift_q;

endmodule

// File: tb/tb_byte_aligner.sv
// Scoreboard bench for byte_aligner with directed frame streams.
module tb_byte_aligner;

  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       locked;
  logic [2:0] shift_mag;

  byte_aligner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .locked    (locked),
    .shift_mag (shift_mag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       lk;
    logic [2:0] sh;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   nword  = 0;
  logic done   = 1'b0;
  logic rst_seen = 1'b0;
  logic vld_seen = 1'b0;
  logic [2:0] last_sh = 3'd0;
  logic       last_lk = 1'b0;

  function automatic logic [7:0] ror8(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] dd;
    dd = {d, d};
    dd = dd >> s;
    return dd[7:0];
  endfunction

  // Fillers have at most 4 ones, so no rotation of them can equal 8'hF4
  function automatic logic [7:0] filler(input int w);
    return {4'h0, 4'(w)};
  endfunction

  task automatic send(input logic [7:0] d, input logic [2:0] sh_now,
                      input logic sof, input logic lk, input logic [2:0] sh_after);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    x.data = ror8(d, sh_now);
    x.sof  = sof;
    x.lk   = lk;
    x.sh   = sh_after;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hF4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hF4;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Sync word then 15 fillers, shift fixed; lk is locked after the sync word
  task automatic frame_std(input logic [7:0] sync, input logic [2:0] sh,
                           input logic sof, input logic lk, input int idle_at);
    send(sync, sh, sof, lk, sh);
    for (int w = 1; w < FRAME; w++) begin
      if (w == idle_at) idle(5);
      send(filler(w), sh, 1'b0, lk, sh);
    end
  endtask

  // Hunting with no match: shift steps after every 16th word
  task automatic hunt_frames(input logic [7:0] sync, input int n);
    for (int f = 0; f < n; f++)
      for (int w = 0; w < FRAME; w++)
        send((w == 0) ? sync : filler(w), 3'(f), 1'b0, 1'b0,
             (w == FRAME - 1) ? 3'(f + 1) : 3'(f));
  endtask

  always @(posedge clk) begin
    rst_seen <= !rst_n;
    vld_seen <= rst_n & in_valid;
  end

  // Monitor: reset / idle / valid-word checks against the scoreboard
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (rst_seen) begin
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sof !== 1'b0 ||
          locked !== 1'b0 || shift_mag !== 3'd0) begin
        errors++;
        $display("FAIL reset: vld %b data %h sof %b locked %b shift %0d, required 0 00 0 0 0",
                 out_valid, out_data, out_sof, locked, shift_mag);
      end
      last_sh = 3'd0;
      last_lk = 1'b0;
    end else if (vld_seen) begin
      checks++;
      if (out_valid !== 1'b1 || q.size() == 0) begin
        errors++;
        $display("FAIL word %0d: out_valid %b queue %0d, required valid with entry",
                 nword, out_valid, q.size());
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_sof !== e.sof || locked !== e.lk ||
            shift_mag !== e.sh) begin
          errors++;
          $display("FAIL word %0d: data %h sof %b locked %b shift %0d, required %h %b %b %0d",
                   nword, out_data, out_sof, locked, shift_mag, e.data, e.sof, e.lk, e.sh);
        end
        last_sh = e.sh;
        last_lk = e.lk;
      end
      nword++;
    end else begin
      checks++;
      if (out_valid !== 1'b0 || out_sof !== 1'b0 || locked !== last_lk ||
          shift_mag !== last_sh) begin
        errors++;
        $display("FAIL idle: vld %b sof %b locked %b shift %0d, required 0 0 %b %0d",
                 out_valid, out_sof, locked, shift_mag, last_lk, last_sh);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Aligned stream: lock after word 32, sof at 48; idle gap mid-frame 3
    frame_std(8'hF4, 3'd0, 1'b0, 1'b0, 0);
    frame_std(8'hF4, 3'd0, 1'b0, 1'b0, 0);
    frame_std(8'hF4, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'hF4, 3'd0, 1'b1, 1'b1, 6);
    frame_std(8'hF4, 3'd0, 1'b1, 1'b1, 0);
    // Three missed syncs then a good one: lock held
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'hF4, 3'd0, 1'b1, 1'b1, 0);
    // Four missed syncs: lock dropped, shift kept
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'h00, 3'd0, 1'b0, 1'b1, 0);
    frame_std(8'h00, 3'd0, 1'b0, 1'b0, 0);
    idle(2);

    // Sync rotated left by 3: hunt 0..3, then lock, locked sync reads F4
    do_reset();
    idle(1);
    hunt_frames(8'hA7, 3);
    frame_std(8'hA7, 3'd3, 1'b0, 1'b0, 0);
    frame_std(8'hA7, 3'd3, 1'b0, 1'b0, 0);
    frame_std(8'hA7, 3'd3, 1'b0, 1'b1, 0);
    frame_std(8'hA7, 3'd3, 1'b1, 1'b1, 0);

    // Verify at shift 7, corrupted sync wraps shift to 0
    do_reset();
    idle(1);
    hunt_frames(8'h7A, 7);
    frame_std(8'h7A, 3'd7, 1'b0, 1'b0, 0);
    send(8'h00, 3'd7, 1'b0, 1'b0, 3'd0);
    send(filler(5), 3'd0, 1'b0, 1'b0, 3'd0);

    // Reset during VERIFY with in_valid high
    do_reset();
    send(8'hF4, 3'd0, 1'b0, 1'b0, 3'd0);
    for (int w = 1; w < 6; w++) send(filler(w), 3'd0, 1'b0, 1'b0, 3'd0);
    do_reset();
    send(filler(3), 3'd0, 1'b0, 1'b0, 3'd0);
    idle(3);

    done = 1'b1;
  end

endmodule
